psum_writeback: RTL

Post-processing and write-back stage that sits directly downstream of a PE's psum output FIFO. It consumes 32-bit partial sums over a valid/ready handshake. Each sum is requantized to 8 bits by arithmetic right shift and signed saturation. Four results are packed per 32-bit word and written to consecutive global-buffer addresses under a stall-able write handshake.

---
 rtl/psum_writeback.sv | 100 ++++++++++
 1 files changed

// File: rtl/psum_writeback.sv
// psum_writeback: requantizes 32-bit psums to 8-bit lanes, packs four per word and writes them to the global buffer.
// Optional ReLU clamp on each lane when PSUM_WB_RELU_EN is defined.
module psum_writeback #(
  parameter int PSUM_BUS_BITWIDTH  = 32,
  parameter int DATA_BITWIDTH      = 8,
  parameter int N_CHUNKS           = PSUM_BUS_BITWIDTH / DATA_BITWIDTH,
  parameter int GBUF_ADDR_BITWIDTH = 10,
  parameter int CNT_BITWIDTH       = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [GBUF_ADDR_BITWIDTH-1:0] i_base_addr,
  input  logic [CNT_BITWIDTH-1:0]       i_num_psum,
  input  logic [4:0]                    i_shift,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic [PSUM_BUS_BITWIDTH-1:0]  i_psum_data,
  input  logic                          i_psum_valid,
  output logic                          o_psum_ready,
  output logic                          o_gbuf_we,
  output logic [GBUF_ADDR_BITWIDTH-1:0] o_gbuf_addr,
  output logic [PSUM_BUS_BITWIDTH-1:0]  o_gbuf_wdata,
  input  logic                          i_gbuf_ready
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int LW = N_CHUNKS > 1 ? $clog2(N_CHUNKS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N_CHUNKS - 1);
  localparam logic signed [PSUM_BUS_BITWIDTH-1:0] SAT_MAX = PSUM_BUS_BITWIDTH'((1 << (DATA_BITWIDTH - 1)) - 1);
  localparam logic signed [PSUM_BUS_BITWIDTH-1:0] SAT_MIN = ~SAT_MAX;
  logic [1:0] state;
  logic [GBUF_ADDR_BITWIDTH-1:0] base_q, widx_q;
  logic [CNT_BITWIDTH-1:0] rem_q;
  logic [4:0] shift_q;
  logic [LW-1:0] lane_cnt;
  logic [PSUM_BUS_BITWIDTH-1:0] pack_q, next_pack;
  logic signed [PSUM_BUS_BITWIDTH-1:0] shifted;
  logic [DATA_BITWIDTH-1:0] lane;
  logic last, fills, accept, issue;
  assign shifted = $signed(i_psum_data) >>> shift_q;
`ifdef PSUM_WB_RELU_EN
  assign lane = shifted < 0 ? '0 : shifted > SAT_MAX ? SAT_MAX[DATA_BITWIDTH-1:0] : shifted[DATA_BITWIDTH-1:0];
`else
  assign lane = shifted > SAT_MAX ? SAT_MAX[DATA_BITWIDTH-1:0] :
                shifted < SAT_MIN ? SAT_MIN[DATA_BITWIDTH-1:0] : shifted[DATA_BITWIDTH-1:0];
`endif
  assign last = rem_q == CNT_BITWIDTH'(1);
  // The last psum also completes a word, so it must wait for a pending write too.
  assign fills = lane_cnt == LAST_LANE || last;
  assign o_psum_ready = state == RUN && !(o_gbuf_we && !i_gbuf_ready && fills);
  assign accept = i_psum_valid && o_psum_ready;
  assign issue = accept && fills;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  always_comb begin
    next_pack = pack_q;
    next_pack[int'(lane_cnt) * DATA_BITWIDTH +: DATA_BITWIDTH] = lane;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      base_q       <= '0;
      widx_q       <= '0;
      rem_q        <= '0;
      shift_q      <= '0;
      lane_cnt     <= '0;
      pack_q       <= '0;
      o_gbuf_we    <= 1'b0;
      o_gbuf_addr  <= '0;
      o_gbuf_wdata <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        state    <= i_num_psum == '0 ? DONE : RUN;
        base_q   <= i_base_addr;
        rem_q    <= i_num_psum;
        shift_q  <= i_shift;
        lane_cnt <= '0;
        widx_q   <= '0;
        pack_q   <= '0;
      end
      if (state == DRAIN && (!o_gbuf_we || i_gbuf_ready)) state <= DONE;
      if (state == DONE) state <= IDLE;
      if (accept) begin
        rem_q    <= rem_q - 1'b1;
        lane_cnt <= issue ? '0 : lane_cnt + 1'b1;
        pack_q   <= issue ? '0 : next_pack;
        if (last) state <= DRAIN;
      end
      if (issue) begin
        o_gbuf_wdata <= next_pack;
        o_gbuf_addr  <= base_q + widx_q;
        widx_q       <= widx_q + 1'b1;
      end
      o_gbuf_we <= issue || (o_gbuf_we && !i_gbuf_ready);
    end
  end
endmodule
